// File: rtl/clock_pkg.sv
// Shared constants, state encoding and sizing helper for the BCD-to-binary path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clock_pkg;

  // Width of one packed BCD digit
  localparam int BCD_W = 4;

  // Largest legal decimal digit value; anything above is an invalid BCD code
  localparam int BCD_MAX_DIGIT = 9;

  // Converter control states
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Smallest binary width w such that 2^w > 10^num_digits - 1
  function automatic int req_out_w(input int num_digits);
    longint unsigned lim;
    int              w;
    lim = 64'd1;
    for (int i = 0; i < num_digits; i++) begin
      lim = lim * 64'd10;
    end
    w = 63;
    for (int k = 62; k >= 0; k--) begin
      if ((64'd1 << k) >= lim) begin
        w = k;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10_step.sv
// One multiply-by-ten-and-add step: acc_out = acc_in*10 + digit, truncated to OUT_W.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module bcd_mac10_step
  import clock_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic [OUT_W-1:0] acc_in,
  input  logic [BCD_W-1:0] digit,
  output logic [OUT_W-1:0] acc_out
);

  // Four guard bits hold the full *10 product before truncation back to OUT_W
  localparam int WIDE_W = OUT_W + 4;

  logic [WIDE_W-1:0] w_acc_ext;

  assign w_acc_ext = {4'b0000, acc_in};

  // acc*10 as (acc<<3)+(acc<<1); modulo 2^OUT_W wrap happens in the final cast
  assign acc_out = OUT_W'((w_acc_ext << 3) + (w_acc_ext << 1) + WIDE_W'(digit));

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit (MSD first) per clock; optional macro BCD_DIGIT_CHECK_EN flags digits > 9.
// Latency: result and one-cycle valid at start edge + NUM_DIGITS; one result per NUM_DIGITS+1 cycles back-to-back.
// Backpressure: start is only honoured while busy=0; starts during a conversion are dropped. Reset release is expected pre-synchronised.
module bcd_to_bin_seq
  import clock_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic                        busy,
  output logic                        valid,
  output logic [OUT_W-1:0]            bin_out,
  output logic                        err
);

  localparam int IN_W  = BCD_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Refuse to build a result register too narrow for the largest decimal value
  generate
    if (OUT_W < req_out_w(NUM_DIGITS)) begin : g_width_check
      $error("OUT_W too small for NUM_DIGITS");
    end
  endgenerate

  conv_state_t      r_state;
  logic [IN_W-1:0]  r_digits;
  logic [OUT_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_valid;
  logic [OUT_W-1:0] r_bin;

  logic [BCD_W-1:0] w_msd;
  logic [OUT_W-1:0] w_acc_next;

  // The digit being folded in is always the top nibble of the shift register
  assign w_msd = r_digits[IN_W-1 -: BCD_W];

  bcd_mac10_step #(
    .OUT_W (OUT_W)
  ) u_mac10 (
    .acc_in  (r_acc),
    .digit   (w_msd),
    .acc_out (w_acc_next)
  );

`ifdef BCD_DIGIT_CHECK_EN
  logic r_bad;
  logic r_err;
  logic w_bad_now;

  // Sticky flag including the digit consumed this cycle, so the last digit counts too
  assign w_bad_now = r_bad | (w_msd > BCD_W'(BCD_MAX_DIGIT));
`endif

  // Control FSM with registered outputs: capture on start, fold one digit per edge, publish on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_bin    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      r_bad    <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_digits <= bcd_in;
            r_acc    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CONV;
`ifdef BCD_DIGIT_CHECK_EN
            r_bad    <= 1'b0;
`endif
          end
        end
        CONV: begin
          r_acc    <= w_acc_next;
          r_digits <= r_digits << BCD_W;
          r_idx    <= r_idx + 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          r_bad    <= w_bad_now;
`endif
          if (r_idx == LAST_IDX) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_idx   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            r_bin   <= w_bad_now ? '0 : w_acc_next;
            r_err   <= w_bad_now;
`else
            r_bin   <= w_acc_next;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign valid   = r_valid;
  assign bin_out = r_bin;
`ifdef BCD_DIGIT_CHECK_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: directed cases with literal results plus randomized traffic
// checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int ND    = 3;
  localparam int OUT_W = 10;
  localparam int IN_W  = 4 * ND;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             start  = 1'b0;
  logic [IN_W-1:0]  bcd_in = '0;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] bin_out;
  logic             err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(
    .NUM_DIGITS (ND),
    .OUT_W      (OUT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain decimal value of the packed digits, raw nibbles weighted by powers of ten
  function automatic int model_value(input logic [IN_W-1:0] b);
    int v;
    int wgt;
    v = 0;
    wgt = 1;
    for (int k = 0; k < ND; k++) begin
      v = v + int'(b[4*k +: 4]) * wgt;
      wgt = wgt * 10;
    end
    return v;
  endfunction

  function automatic logic model_bad(input logic [IN_W-1:0] b);
    for (int k = 0; k < ND; k++) begin
      if (b[4*k +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [OUT_W-1:0] model_bin(input logic [IN_W-1:0] b);
`ifdef BCD_DIGIT_CHECK_EN
    if (model_bad(b)) return '0;
`endif
    return OUT_W'(model_value(b) % (1 << OUT_W));
  endfunction

  function automatic logic model_err(input logic [IN_W-1:0] b);
`ifdef BCD_DIGIT_CHECK_EN
    return model_bad(b);
`else
    return 1'b0 & model_bad(b);
`endif
  endfunction

  // Reference model: remaining-cycle countdown per accepted request
  int               m_cnt   = 0;
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_bin   = '0;
  logic             m_err   = 1'b0;
  logic [OUT_W-1:0] m_pbin  = '0;
  logic             m_perr  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      m_bin   = '0;
      m_err   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_bin   = m_pbin;
          m_err   = m_perr;
        end
      end else if (start) begin
        m_cnt  = ND;
        m_pbin = model_bin(bcd_in);
        m_perr = model_err(bcd_in);
      end
    end
  end

  // Every-cycle comparison against the model, on the inactive edge
  always @(negedge clk) begin
    chk("sb_busy",    busy,    (m_cnt > 0));
    chk("sb_valid",   valid,   m_valid);
    chk("sb_bin_out", bin_out, m_bin);
    if (m_valid) chk("sb_err", err, m_err);
  end

  task automatic pulse_start(input logic [IN_W-1:0] v);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Bounded wait for valid, sampling 1ns after each rising edge
  task automatic wait_valid(input string name, output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_valid_seen"}, valid, 1'b1);
  endtask

  initial begin
    int lat;
    int nv;
    logic [IN_W-1:0] rv;

    // Pin the model with hand-computed values
    chk("model_123", model_value(12'h123), 123);
    chk("model_999", model_value(12'h999), 999);
    chk("model_00A", model_value(12'h00A), 10);
`ifdef BCD_DIGIT_CHECK_EN
    chk("model_FFF", model_bin(12'hFFF), 0);
`else
    chk("model_FFF", model_bin(12'hFFF), 641);
`endif

    #1 rst_n = 1'b0;
    #11;
    chk("rst_busy",  busy,    0);
    chk("rst_valid", valid,   0);
    chk("rst_bin",   bin_out, 0);
    chk("rst_err",   err,     0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x123 -> 123 after three cycles, single-cycle valid
    pulse_start(12'h123);
    wait_valid("d123", lat);
    chk("d123_lat", lat, 3);
    chk("d123_bin", bin_out, 123);
    chk("d123_err", err, 0);
    @(posedge clk); #1;
    chk("d123_valid_width", valid, 0);

    pulse_start(12'h999);
    wait_valid("d999", lat);
    chk("d999_bin", bin_out, 999);
    @(posedge clk); #1;
    chk("d999_valid_width", valid, 0);

    pulse_start(12'h000);
    wait_valid("d000", lat);
    chk("d000_bin", bin_out, 0);

    // start while busy is dropped
    pulse_start(12'h456);
    bcd_in = 12'h789;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_valid("d456", lat);
    chk("d456_lat", lat, 2);
    chk("d456_bin", bin_out, 456);
    pulse_start(12'h789);
    wait_valid("d789", lat);
    chk("d789_bin", bin_out, 789);

    // Reset mid-conversion aborts with no result
    pulse_start(12'h321);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  busy,    0);
    chk("abort_valid", valid,   0);
    chk("abort_bin",   bin_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      nv = nv + int'(valid);
    end
    chk("abort_no_valid", nv, 0);

    // Invalid digit
    pulse_start(12'h00A);
    wait_valid("d00A", lat);
`ifdef BCD_DIGIT_CHECK_EN
    chk("d00A_bin", bin_out, 0);
    chk("d00A_err", err, 1);
`else
    chk("d00A_bin", bin_out, 10);
    chk("d00A_err", err, 0);
`endif

    // Start on the cycle valid is seen is accepted
    pulse_start(12'h007);
    wait_valid("d007", lat);
    chk("d007_bin", bin_out, 7);
    bcd_in = 12'h050;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_valid("d050", lat);
    chk("d050_lat", lat, 3);
    chk("d050_bin", bin_out, 50);

    // Randomized traffic, including starts while busy and invalid nibbles
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rv = IN_W'($urandom);
      end else begin
        for (int k = 0; k < ND; k++) rv[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      bcd_in = rv;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
